capture_ctrl: RTL

//  Parametrised capture/readout controller for the logic-analyser core; successor to the fixed-size controller.

---
 rtl/capture_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: capture/readout controller for the logic-analyser core.
//
// While armed, each strobed sample goes into a ring buffer after its
// disabled byte groups are zeroed. Once the trigger fires, a programmed
// number of post-trigger samples is stored. The last rcnt stored words are
// then streamed to the transmitter, newest first.
//
// Ports
//   clk_i, rst_in      clock, asynchronous active-low reset
//   cmd_i              [15:0] read field, [31:16] delay field, [2+GROUPS-1:2] group mask
//   set_cnt_i          load read/delay fields (IDLE/DONE only)
//   set_flgs_i         load group disable mask (IDLE/DONE only)
//   arm_i, run_i       start capture / trigger level
//   stb_i, smpls_i     sample strobe and data
//   d_i                RAM read data, RD_LAT cycles after addr_o
//   tx_rdy_i           transmitter idle
//   we_o, addr_o, q_o  RAM write enable / address / write data
//   tx_stb_o, tx_o     one-cycle send strobe and held word
//   armed_o, done_o    status: capturing / readout finished
module capture_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 5,
  parameter int RD_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic [31:0]      cmd_i,
  input  logic             set_cnt_i,
  input  logic             set_flgs_i,
  input  logic             arm_i,
  input  logic             run_i,
  input  logic             stb_i,
  input  logic [WIDTH-1:0] smpls_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             tx_rdy_i,
  output logic             we_o,
  output logic [DEPTH-1:0] addr_o,
  output logic [WIDTH-1:0] q_o,
  output logic             tx_stb_o,
  output logic [WIDTH-1:0] tx_o,
  output logic             armed_o,
  output logic             done_o
);
  localparam int          GROUPS = WIDTH / 8;
  localparam logic [18:0] WORDS  = 19'(2 ** DEPTH);

  typedef enum logic [2:0] {IDLE, FILL, POST, RADDR, RWAIT, SEND, DONE} state_t;

  // (field+1)*4 computed one bit wider so a field of 0xFFFF cannot wrap
  // before the clamp to the buffer size.
  function automatic logic [17:0] to_cnt(input logic [15:0] f);
    logic [18:0] raw;
    raw = ({3'b000, f} + 19'd1) << 2;
    return (raw > WORDS) ? WORDS[17:0] : raw[17:0];
  endfunction

  state_t            state;
  logic [15:0]       rd_fld, dl_fld;
  logic [GROUPS-1:0] mask;
  logic [17:0]       rcnt, dcnt, dctr, rctr;
  logic [DEPTH-1:0]  wptr, rptr;
  logic [1:0]        wctr, guard;
  logic [WIDTH-1:0]  masked;
  logic              cfg_ok, stb_ok;

  assign rcnt   = to_cnt(rd_fld);
  assign dcnt   = to_cnt(dl_fld);
  assign cfg_ok = (state == IDLE) || (state == DONE);
  assign stb_ok = stb_i && ((state == FILL) || (state == POST));

  genvar g;
  generate
    for (g = 0; g < GROUPS; g++) begin : g_mask
      assign masked[g*8 +: 8] = mask[g] ? 8'h00 : smpls_i[g*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      rd_fld   <= '0;
      dl_fld   <= '0;
      mask     <= '0;
      dctr     <= '0;
      rctr     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      wctr     <= '0;
      guard    <= '0;
      we_o     <= 1'b0;
      addr_o   <= '0;
      q_o      <= '0;
      tx_stb_o <= 1'b0;
      tx_o     <= '0;
      armed_o  <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      we_o     <= 1'b0;
      tx_stb_o <= 1'b0;

      if (cfg_ok && set_cnt_i) begin
        rd_fld <= cmd_i[15:0];
        dl_fld <= cmd_i[31:16];
      end
      if (cfg_ok && set_flgs_i) mask <= cmd_i[2+GROUPS-1:2];

      // Write path: one registered write per accepted strobe.
      if (stb_ok) begin
        we_o   <= 1'b1;
        addr_o <= wptr;
        q_o    <= masked;
        wptr   <= wptr + 1'b1;
      end

      case (state)
        IDLE, DONE: if (arm_i) begin
          state   <= FILL;
          wptr    <= '0;
          dctr    <= '0;
          armed_o <= 1'b1;
          done_o  <= 1'b0;
        end
        // Counts are at least 4, so a coincident strobe (delay sample 1)
        // can never finish the delay phase on its own.
        FILL: if (run_i) begin
          state <= POST;
          if (stb_i) dctr <= 18'd1;
        end
        POST: if (stb_i) begin
          dctr <= dctr + 18'd1;
          if (dctr + 18'd1 == dcnt) begin
            // The final write lands on wptr in the next cycle, which is
            // also where readout starts; addr_o already points there.
            state   <= RADDR;
            rptr    <= wptr;
            rctr    <= '0;
            armed_o <= 1'b0;
          end
        end
        RADDR: begin
          addr_o <= rptr;
          wctr   <= '0;
          state  <= RWAIT;
        end
        RWAIT: begin
          if (wctr == 2'(RD_LAT - 1)) begin
            tx_o     <= d_i;
            tx_stb_o <= 1'b1;
            guard    <= '0;
            state    <= SEND;
          end else begin
            wctr <= wctr + 2'd1;
          end
        end
        // tx_rdy_i is not trusted in the strobe cycle or the one after it:
        // the transmitter needs that long to drop ready.
        SEND: begin
          if (guard != 2'd2) begin
            guard <= guard + 2'd1;
          end else if (tx_rdy_i) begin
            rctr <= rctr + 18'd1;
            if (rctr + 18'd1 == rcnt) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              rptr   <= rptr - 1'b1;
              addr_o <= rptr - 1'b1;
              state  <= RADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
